// File: rtl/control_unit_pkg.sv
// Opcode/Funct encodings, ALU operation codes and the bundled control strobes
// shared by the MIPS main control decoder and its ALU decoder.
package control_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alucontrol_e;

    typedef struct packed {
        logic   reg_write;
        logic   reg_dst;
        logic   alu_src;
        logic   branch;
        logic   mem_write;
        logic   mem_to_reg;
        aluop_e alu_op;
        logic   jump;
    } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Instruction fields in, registered datapath control out.
// IllegalOp exists only when CU_ILLEGAL_OP_EN is defined.
interface control_unit_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic [1:0] ALUOp;
    logic [2:0] ALUControl;
    logic       MemtoReg;
    logic       MemWrite;
    logic       Branch;
    logic       ALUSrc;
    logic       RegDst;
    logic       RegWrite;
    logic       Jump;
`ifdef CU_ILLEGAL_OP_EN
    logic       IllegalOp;

    modport master (output Op, Funct,
                    input  ALUOp, ALUControl, MemtoReg, MemWrite, Branch,
                           ALUSrc, RegDst, RegWrite, Jump, IllegalOp);
    modport slave  (input  Op, Funct,
                    output ALUOp, ALUControl, MemtoReg, MemWrite, Branch,
                           ALUSrc, RegDst, RegWrite, Jump, IllegalOp);
`else
    modport master (output Op, Funct,
                    input  ALUOp, ALUControl, MemtoReg, MemWrite, Branch,
                           ALUSrc, RegDst, RegWrite, Jump);
    modport slave  (input  Op, Funct,
                    output ALUOp, ALUControl, MemtoReg, MemWrite, Branch,
                           ALUSrc, RegDst, RegWrite, Jump);
`endif
endinterface

// File: rtl/control_unit_alu_decoder.sv
// Combinational (ALUOp, Funct) -> ALUControl. With CU_ILLEGAL_OP_EN it also
// flags an unsupported Funct on the R-type path.
module alu_decoder
    import control_unit_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
`ifdef CU_ILLEGAL_OP_EN
    output logic       funct_illegal,
`endif
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
`ifdef CU_ILLEGAL_OP_EN
        funct_illegal = 1'b0;
`endif
        // Funct is only examined on the R-type path so X/Z elsewhere is harmless.
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alu_control = ALU_ADD;
                    F_SUB:   alu_control = ALU_SUB;
                    F_AND:   alu_control = ALU_AND;
                    F_OR:    alu_control = ALU_OR;
                    F_SLT:   alu_control = ALU_SLT;
                    default: begin
                        alu_control = ALU_AND;
`ifdef CU_ILLEGAL_OP_EN
                        funct_illegal = 1'b1;
`endif
                    end
                endcase
            end
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// MIPS main control decoder with registered outputs (one cycle latency).
// Optional CU_ILLEGAL_OP_EN adds a registered IllegalOp flag.
module control_unit
    import control_unit_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.slave  bus
);

    ctrl_t      ctrl_raw;
    ctrl_t      ctrl_d, ctrl_q;
    logic       op_known;
    logic [2:0] alu_dec_ctrl;
    logic [2:0] alu_control_d, alu_control_q;
`ifdef CU_ILLEGAL_OP_EN
    logic       funct_bad;
    logic       illegal_d, illegal_q;
`endif

    always_comb begin
        ctrl_raw = '0;
        op_known = 1'b1;
        case (bus.Op)
            OP_RTYPE: begin
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.reg_dst   = 1'b1;
                ctrl_raw.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.alu_src    = 1'b1;
                ctrl_raw.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl_raw.alu_src   = 1'b1;
                ctrl_raw.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_raw.branch = 1'b1;
                ctrl_raw.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.alu_src   = 1'b1;
            end
            OP_J:     ctrl_raw.jump = 1'b1;
            default:  op_known = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op        (ctrl_raw.alu_op),
        .funct         (bus.Funct),
`ifdef CU_ILLEGAL_OP_EN
        .funct_illegal (funct_bad),
`endif
        .alu_control   (alu_dec_ctrl)
    );

    // Unknown opcodes are a NOP: every output, ALUControl included, goes to 0.
    always_comb begin
        ctrl_d        = ctrl_raw;
        alu_control_d = op_known ? alu_dec_ctrl : ALU_AND;
`ifdef CU_ILLEGAL_OP_EN
        illegal_d = !op_known || funct_bad;
        if (funct_bad) begin
            ctrl_d.reg_write = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q        <= '0;
            alu_control_q <= '0;
`ifdef CU_ILLEGAL_OP_EN
            illegal_q     <= 1'b0;
`endif
        end else begin
            ctrl_q        <= ctrl_d;
            alu_control_q <= alu_control_d;
`ifdef CU_ILLEGAL_OP_EN
            illegal_q     <= illegal_d;
`endif
        end
    end

    assign bus.RegWrite   = ctrl_q.reg_write;
    assign bus.RegDst     = ctrl_q.reg_dst;
    assign bus.ALUSrc     = ctrl_q.alu_src;
    assign bus.Branch     = ctrl_q.branch;
    assign bus.MemWrite   = ctrl_q.mem_write;
    assign bus.MemtoReg   = ctrl_q.mem_to_reg;
    assign bus.ALUOp      = ctrl_q.alu_op;
    assign bus.Jump       = ctrl_q.jump;
    assign bus.ALUControl = alu_control_q;
`ifdef CU_ILLEGAL_OP_EN
    assign bus.IllegalOp  = illegal_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed test-plan sequence then random Op/Funct/reset,
// each edge compared against a table-driven model of the decode rules.
module tb_control_unit;

`ifdef CU_ILLEGAL_OP_EN
    localparam int W = 13;
`else
    localparam int W = 12;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [W-1:0] exp_q[$];

    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Rows in the order RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, ALUOp[1:0], Jump
    logic [5:0] op_tab  [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    logic [8:0] row_tab [6] = '{9'b110000100, 9'b101001000, 9'b001010000,
                                9'b000100010, 9'b101000000, 9'b000000001};
    logic [5:0] fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] fn_ctl  [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

    function automatic logic [W-1:0] model(input logic [5:0] op, input logic [5:0] fn);
        logic [8:0] row;
        logic [2:0] ctl;
        logic       found, fn_ok, illegal;
        row = '0; ctl = 3'b000; found = 1'b0; fn_ok = 1'b0;
        for (int i = 0; i < 6; i++)
            if (op === op_tab[i]) begin row = row_tab[i]; found = 1'b1; end
        if (found) begin
            case (row[2:1])
                2'b00:   ctl = 3'b010;
                2'b01:   ctl = 3'b110;
                2'b11:   ctl = 3'b010;
                default: begin
                    ctl = 3'b000;
                    for (int k = 0; k < 5; k++)
                        if (fn === fn_tab[k]) begin ctl = fn_ctl[k]; fn_ok = 1'b1; end
                end
            endcase
        end
        illegal = !found || (op === 6'b000000 && !fn_ok);
`ifdef CU_ILLEGAL_OP_EN
        if (found && illegal) row[8] = 1'b0;
        return {row, ctl, illegal};
`else
        if (illegal && !found) ctl = 3'b000;
        return {row, ctl};
`endif
    endfunction

    function automatic logic [W-1:0] observe();
`ifdef CU_ILLEGAL_OP_EN
        return {bus.RegWrite, bus.RegDst, bus.ALUSrc, bus.Branch, bus.MemWrite,
                bus.MemtoReg, bus.ALUOp, bus.Jump, bus.ALUControl, bus.IllegalOp};
`else
        return {bus.RegWrite, bus.RegDst, bus.ALUSrc, bus.Branch, bus.MemWrite,
                bus.MemtoReg, bus.ALUOp, bus.Jump, bus.ALUControl};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply one edge of stimulus and compare the registered result just after it.
    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input string tag, input bit xcheck = 1'b0);
        logic [W-1:0] got;
        @(negedge clk);
        rst_n    = r;
        bus.Op    = op;
        bus.Funct = fn;
        exp_q.push_back(r ? model(op, fn) : '0);
        @(posedge clk);
        #1;
        got = observe();
        check(tag, 32'(got), 32'(exp_q.pop_front()));
        if (xcheck) check({tag, "_noX"}, 32'($isunknown(got)), 32'd0);
    endtask

    initial begin
        bus.Op    = 6'b100011;
        bus.Funct = 6'b000000;

        step(1'b0, 6'b100011, 6'b000000, "rst0");
        step(1'b0, 6'b100011, 6'b000000, "rst1");
        step(1'b1, 6'b100011, 6'b000000, "lw_after_rst");

        step(1'b1, 6'b000000, 6'b100000, "r_add");
        step(1'b1, 6'b000000, 6'b101010, "r_slt");
        step(1'b1, 6'b000000, 6'b100010, "r_sub");
        step(1'b1, 6'b000000, 6'b100100, "r_and");
        step(1'b1, 6'b000000, 6'b100101, "r_or");
        step(1'b1, 6'b100011, 6'bxxxxxx, "lw_fx", 1'b1);
        step(1'b1, 6'b101011, 6'bxxxxxx, "sw_fx", 1'b1);
        step(1'b1, 6'b000100, 6'bxxxxxx, "beq_fx", 1'b1);
        step(1'b1, 6'b000010, 6'b000000, "j");
        step(1'b1, 6'b001000, 6'b000000, "addi");
        step(1'b1, 6'b111111, 6'b000000, "unk_op");
        step(1'b1, 6'b000000, 6'b000111, "r_bad_funct");
        step(1'b0, 6'bxxxxxx, 6'b000000, "rst_opx");

        for (int i = 0; i < 8; i++)
            step(i != 4, (i % 2 == 0) ? 6'b000000 : 6'b100011, 6'b100000, "mid_rst");

        for (int i = 0; i < 400; i++) begin
            int         s;
            logic [5:0] op, fn;
            s  = $urandom_range(0, 7);
            op = (s < 6) ? op_tab[s] : 6'($urandom_range(0, 63));
            s  = $urandom_range(0, 6);
            fn = (s < 5) ? fn_tab[s] : 6'($urandom_range(0, 63));
            step($urandom_range(0, 19) != 0, op, fn, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
